// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Oversampling 8N1 UART receiver. The serial input is synchronized into the
// clk domain, a start edge is validated at the middle of the start bit, the
// eight data bits are sampled at their centres (LSB first) and the stop bit
// decides whether the byte is delivered, dropped as an overrun, or reported
// as a framing error.
//
// Parameters
//   OVERSAMPLE   clk cycles per bit (even, 8..64)
//   SYNC_STAGES  depth of the rxInput synchronizer (>= 2)
//
// Ports
//   clk           single clock, OVERSAMPLE x baud rate, posedge
//   rst           asynchronous active-low reset
//   rxInput       serial line, asynchronous to clk, idle high
//   rxRead        consumer acknowledge; clears rxValid
//   byteReceived  last good byte, stable while rxValid is high
//   rxValid       high while byteReceived holds an unread byte
//   framingError  one-cycle pulse when the stop bit is sampled low
//   overrun       one-cycle pulse when a good byte is dropped (rxValid busy)
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxInput,
    input  logic       rxRead,
    output logic [7:0] byteReceived,
    output logic       rxValid,
    output logic       framingError,
    output logic       overrun
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

    // Tick at which the start bit is re-checked (its centre) and tick at
    // which data/stop bits are sampled (one full bit period later each time).
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_sync;

    state_t                 state;
    state_t                 state_next;
    logic [TICK_W-1:0]      tick;
    logic [TICK_W-1:0]      tick_next;
    logic [2:0]             bit_cnt;
    logic [2:0]             bit_cnt_next;
    logic [7:0]             shift_reg;
    logic [7:0]             shift_next;
    logic                   armed;
    logic                   armed_next;

    logic [7:0]             byte_next;
    logic                   valid_next;
    logic                   ferr_next;
    logic                   ovr_next;

    // -----------------------------------------------------------------------
    // Input synchronizer, reset to the idle (high) line level
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxInput};
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tick         <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            armed        <= 1'b1;
            byteReceived <= '0;
            rxValid      <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_next;
            tick         <= tick_next;
            bit_cnt      <= bit_cnt_next;
            shift_reg    <= shift_next;
            armed        <= armed_next;
            byteReceived <= byte_next;
            rxValid      <= valid_next;
            framingError <= ferr_next;
            overrun      <= ovr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        tick_next    = tick;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        armed_next   = armed;
        byte_next    = byteReceived;
        valid_next   = rxValid;
        ferr_next    = 1'b0;
        ovr_next     = 1'b0;

        // Acknowledge; a read while nothing is pending is harmless. A byte
        // delivered in the same cycle (STOP below) overrides this clear.
        if (rxRead) begin
            valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                tick_next    = '0;
                bit_cnt_next = '0;
                if (!armed) begin
                    // After a framing error the line must return high
                    // before a new start edge is accepted, so a held-low
                    // break line reports only once.
                    if (rx_sync) begin
                        armed_next = 1'b1;
                    end
                end else if (!rx_sync) begin
                    state_next = START;
                end
            end

            START: begin
                if (tick == TICK_HALF) begin
                    tick_next    = '0;
                    bit_cnt_next = '0;
                    // High at the start-bit centre means it was a glitch.
                    state_next   = rx_sync ? IDLE : DATA;
                end else begin
                    tick_next = tick + TICK_W'(1);
                end
            end

            DATA: begin
                if (tick == TICK_LAST) begin
                    tick_next    = '0;
                    shift_next   = {rx_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    tick_next = tick + TICK_W'(1);
                end
            end

            STOP: begin
                if (tick == TICK_LAST) begin
                    tick_next  = '0;
                    state_next = IDLE;
                    if (rx_sync) begin
                        if (!rxValid || rxRead) begin
                            byte_next  = shift_reg;
                            valid_next = 1'b1;
                        end else begin
                            ovr_next = 1'b1;
                        end
                    end else begin
                        ferr_next  = 1'b1;
                        armed_next = 1'b0;
                    end
                end else begin
                    tick_next = tick + TICK_W'(1);
                end
            end

            default: begin
                state_next   = IDLE;
                tick_next    = '0;
                bit_cnt_next = '0;
                armed_next   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed bench for uart_receiver (OVERSAMPLE=16, SYNC_STAGES=2). Frames are
// driven as timed bit sequences; a transaction-level model predicts, for each
// frame, what the receiver reports one fixed latency after its start edge
// (deliver / overrun / framing error) and how rxRead clears rxValid. The
// outputs are compared with the model on every falling clock edge; a few
// literal expectations pin the model itself.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int unsigned OS      = 16;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned CLK_T   = 100;
    localparam int unsigned BIT_NOM = OS * CLK_T;
    // Start edge driven 1 time unit after a rising edge: outcome edge is
    // 9.5 bit periods plus synchronizer depth plus one cycle later.
    localparam int unsigned LAT     = SYNC + 1 + (19 * OS) / 2;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       rx_line = 1'b1;
    logic       rx_read = 1'b0;
    logic [7:0] byte_rx;
    logic       rx_valid;
    logic       frame_err;
    logic       ovr;

    uart_receiver #(
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxInput      (rx_line),
        .rxRead       (rx_read),
        .byteReceived (byte_rx),
        .rxValid      (rx_valid),
        .framingError (frame_err),
        .overrun      (ovr)
    );

    always #(CLK_T / 2) clk = ~clk;

    typedef struct {
        int unsigned due;
        bit          ok;
        logic [7:0]  data;
    } ev_t;

    ev_t         ev_q[$];
    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic        m_valid  = 1'b0;
    logic [7:0]  m_byte   = 8'h00;
    logic        m_fe     = 1'b0;
    logic        m_ov     = 1'b0;

    int unsigned fe_cnt   = 0;
    int unsigned ov_cnt   = 0;
    int unsigned rise_cyc = 0;
    logic        prev_valid = 1'b0;

    int unsigned fall;
    int unsigned fall2;
    int unsigned base;
    int unsigned due2;

    logic [7:0]  baud_data [3] = '{8'h00, 8'hFF, 8'h96};
    int unsigned baud_bt   [2] = '{1552, 1648};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_byte  = 8'h00;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        ev_q.delete();
    endtask

    task automatic model_step();
        ev_t ev;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (ev_q.size() != 0 && ev_q[0].due == cyc) begin
            ev = ev_q.pop_front();
            if (!ev.ok) begin
                m_fe = 1'b1;
            end else if (!m_valid || rx_read) begin
                m_byte  = ev.data;
                m_valid = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else if (rx_read && m_valid) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_byte();
        idle(5);
        rx_read = 1'b1;
        idle(1);
        rx_read = 1'b0;
    endtask

    // Caller is 1 unit after a rising edge; line is left at the stop level.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                              input int unsigned bit_t, output int unsigned t_fall);
        ev_t ev;
        t_fall  = cyc;
        ev.due  = cyc + LAT;
        ev.ok   = stop_ok;
        ev.data = data;
        ev_q.push_back(ev);
        rx_line = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx_line = data[i];
            #(bit_t);
        end
        rx_line = stop_ok;
        #(bit_t);
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                cyc++;
                if (!rst) model_reset();
                else      model_step();
            end
            forever begin
                @(negedge rst);
                model_reset();
            end
            forever begin
                @(negedge clk);
                check("rxValid",      {31'd0, rx_valid},  {31'd0, m_valid});
                check("byteReceived", {24'd0, byte_rx},   {24'd0, m_byte});
                check("framingError", {31'd0, frame_err}, {31'd0, m_fe});
                check("overrun",      {31'd0, ovr},       {31'd0, m_ov});
                if (rx_valid && !prev_valid) rise_cyc = cyc;
                prev_valid = rx_valid;
                fe_cnt += 32'(frame_err);
                ov_cnt += 32'(ovr);
            end
        join_none

        // Reset state
        idle(4);
        check("reset_valid", {31'd0, rx_valid},  32'd0);
        check("reset_byte",  {24'd0, byte_rx},   32'd0);
        check("reset_ferr",  {31'd0, frame_err}, 32'd0);
        check("reset_ovr",   {31'd0, ovr},       32'd0);
        rst = 1'b1;
        idle(20);

        // Single frame 0xA5: latency, hold until read
        send_frame(8'hA5, 1'b1, BIT_NOM, fall);
        idle(100);
        check("a5_latency", rise_cyc - fall, 32'd155);
        check("a5_byte",    {24'd0, byte_rx},  32'hA5);
        check("a5_held",    {31'd0, rx_valid}, 32'd1);
        rx_read = 1'b1;
        idle(1);
        rx_read = 1'b0;
        idle(2);
        check("a5_cleared", {31'd0, rx_valid}, 32'd0);
        // Read with nothing pending is ignored
        rx_read = 1'b1;
        idle(1);
        rx_read = 1'b0;
        idle(10);

        // 5-cycle glitch on idle line
        base = fe_cnt + ov_cnt;
        rx_line = 1'b0;
        idle(5);
        rx_line = 1'b1;
        idle(40);
        check("glitch_pulses", fe_cnt + ov_cnt - base, 32'd0);
        check("glitch_valid",  {31'd0, rx_valid}, 32'd0);

        // Framing error followed by a 40-bit break
        base = fe_cnt;
        send_frame(8'h3C, 1'b0, BIT_NOM, fall);
        #(40 * BIT_NOM);
        rx_line = 1'b1;
        idle(60);
        check("break_fe_count", fe_cnt - base, 32'd1);
        check("break_byte",     {24'd0, byte_rx},  32'hA5);
        check("break_valid",    {31'd0, rx_valid}, 32'd0);

        // Back-to-back 0x11, 0x22 without read: overrun keeps 0x11
        base = ov_cnt;
        send_frame(8'h11, 1'b1, BIT_NOM, fall);
        send_frame(8'h22, 1'b1, BIT_NOM, fall2);
        idle(20);
        check("ovr_count", ov_cnt - base, 32'd1);
        check("ovr_byte",  {24'd0, byte_rx}, 32'h11);
        read_byte();
        idle(10);

        // Same pair, read in the stop-sample cycle of 0x22
        base = ov_cnt;
        due2 = cyc + 10 * OS + LAT;
        fork
            begin
                send_frame(8'h11, 1'b1, BIT_NOM, fall);
                send_frame(8'h22, 1'b1, BIT_NOM, fall2);
            end
            begin
                while (cyc < due2 - 1) idle(1);
                rx_read = 1'b1;
                idle(1);
                rx_read = 1'b0;
            end
        join
        idle(20);
        check("rdstop_ovr",   ov_cnt - base, 32'd0);
        check("rdstop_byte",  {24'd0, byte_rx},  32'h22);
        check("rdstop_valid", {31'd0, rx_valid}, 32'd1);
        read_byte();
        idle(10);

        // Reset in the middle of data bit 4 of 0xFF
        base = fe_cnt + ov_cnt;
        rx_line = 1'b0;
        #(BIT_NOM);
        for (int i = 0; i < 4; i++) begin
            rx_line = 1'b1;
            #(BIT_NOM);
        end
        #(BIT_NOM / 2);
        rst = 1'b0;
        #30;
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_byte",  {24'd0, byte_rx},  32'd0);
        @(posedge clk);
        #1;
        rx_line = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(30);
        send_frame(8'h5A, 1'b1, BIT_NOM, fall);
        idle(20);
        check("midrst_pulses", fe_cnt + ov_cnt - base, 32'd0);
        check("after_rst_byte", {24'd0, byte_rx}, 32'h5A);
        read_byte();
        idle(10);

        // Baud rate -3% / +3% bit periods
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) begin
                send_frame(baud_data[k], 1'b1, baud_bt[b], fall);
                idle(20);
                check("baud_byte", {24'd0, byte_rx}, {24'd0, baud_data[k]});
                read_byte();
                idle(20);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
